// File: rtl/mc_pkg.sv
// Shared types and ISA constants for the multicycle MIPS core.
// Imported by the controller and the datapath top.
package mc_pkg;

   typedef enum logic [3:0] {
      StReset,
      StFetch,
      StDecode,
      StMemAdr,
      StMemRd,
      StMemWb,
      StMemWr,
      StExec,
      StAluWb,
      StBranch,
      StAddiEx,
      StAddiWb,
      StJump,
      StHalt
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   typedef enum logic [2:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluOr,
      AluSlt
   } alu_op_t;

   typedef enum logic [1:0] {
      AluBReg,
      AluBFour,
      AluBImm,
      AluBImmSh
   } alu_b_t;

   typedef enum logic [1:0] {
      PcAlu,
      PcAluOut,
      PcJump
   } pc_src_t;

   function automatic logic [31:0] sext16(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage

// File: rtl/mc_ctrl.sv
// FSM controller of the multicycle core: decodes state and IR fields into
// register enables, mux selects and memory-port strobes.
module mc_ctrl
   import mc_pkg::*;
#(
   parameter bit ENABLE_J = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       a_eq_b,
   input  logic       mem_ready,
   output logic       ir_we,
   output logic       pc_we,
   output pc_src_t    pc_src,
   output logic       ab_we,
   output logic       mdr_we,
   output logic       aluout_we,
   output logic       alu_src_a,
   output alu_b_t     alu_src_b,
   output alu_op_t    alu_op,
   output logic       rf_we,
   output logic       rf_dst_rd,
   output logic       rf_from_mdr,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       retire,
   output logic       halted
);

   state_t state_q, state_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StReset;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_src      = PcAlu;
      ab_we       = 1'b0;
      mdr_we      = 1'b0;
      aluout_we   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = AluBFour;
      alu_op      = AluAdd;
      rf_we       = 1'b0;
      rf_dst_rd   = 1'b0;
      rf_from_mdr = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      iord        = 1'b0;
      retire      = 1'b0;
      halted      = 1'b0;

      case (state_q)
         StReset: state_d = StFetch;
         StFetch: begin
            // Default ALU selects give PC+4.
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = StDecode;
            end
         end
         StDecode: begin
            ab_we     = 1'b1;
            aluout_we = 1'b1;
            alu_src_b = AluBImmSh;
            case (opcode)
               OP_LW, OP_SW: state_d = StMemAdr;
               OP_RTYPE:     state_d = StExec;
               OP_BEQ:       state_d = StBranch;
               OP_ADDI:      state_d = StAddiEx;
               OP_J:         state_d = ENABLE_J ? StJump : StHalt;
               default:      state_d = StHalt;
            endcase
         end
         StMemAdr: begin
            alu_src_a = 1'b1;
            alu_src_b = AluBImm;
            aluout_we = 1'b1;
            state_d   = (opcode == OP_LW) ? StMemRd : StMemWr;
         end
         StMemRd: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               mdr_we  = 1'b1;
               state_d = StMemWb;
            end
         end
         StMemWb: begin
            rf_we       = 1'b1;
            rf_from_mdr = 1'b1;
            retire      = 1'b1;
            state_d     = StFetch;
         end
         StMemWr: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = StFetch;
            end
         end
         StExec: begin
            alu_src_a = 1'b1;
            alu_src_b = AluBReg;
            aluout_we = 1'b1;
            state_d   = StAluWb;
            case (funct)
               FUNCT_ADD: alu_op = AluAdd;
               FUNCT_SUB: alu_op = AluSub;
               FUNCT_AND: alu_op = AluAnd;
               FUNCT_OR:  alu_op = AluOr;
               FUNCT_SLT: alu_op = AluSlt;
               default: begin
                  aluout_we = 1'b0;
                  state_d   = StHalt;
               end
            endcase
         end
         StAluWb: begin
            rf_we     = 1'b1;
            rf_dst_rd = 1'b1;
            retire    = 1'b1;
            state_d   = StFetch;
         end
         StBranch: begin
            pc_we   = a_eq_b;
            pc_src  = PcAluOut;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StAddiEx: begin
            alu_src_a = 1'b1;
            alu_src_b = AluBImm;
            aluout_we = 1'b1;
            state_d   = StAddiWb;
         end
         StAddiWb: begin
            rf_we   = 1'b1;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StJump: begin
            pc_we   = 1'b1;
            pc_src  = PcJump;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StHalt: halted = 1'b1;
         default: state_d = StReset;
      endcase
   end

endmodule

// File: rtl/multicycle_core.sv
// Multicycle MIPS subset core: datapath registers, register file and ALU,
// sequenced by mc_ctrl over a single shared req/ready memory port.
module multicycle_core
   import mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned ADDR_W   = 32,
   parameter bit          ENABLE_J = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              retire,
   output logic              halted,
   output logic [31:0]       pc_dbg
);

   logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
   logic [31:0] rf [32];

   logic        ir_we, pc_we, ab_we, mdr_we, aluout_we;
   logic        alu_src_a, rf_we, rf_dst_rd, rf_from_mdr, iord;
   pc_src_t     pc_src;
   alu_b_t      alu_src_b;
   alu_op_t     alu_op;

   logic [4:0]  rs, rt, rd, rf_waddr;
   logic [31:0] imm_ext, rf_rs, rf_rt, rf_wdata;
   logic [31:0] alu_a, alu_b, alu_y, pc_next, addr_full;

   assign rs      = ir_q[25:21];
   assign rt      = ir_q[20:16];
   assign rd      = ir_q[15:11];
   assign imm_ext = sext16(ir_q[15:0]);

   mc_ctrl #(
      .ENABLE_J (ENABLE_J)
   ) u_ctrl (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (ir_q[31:26]),
      .funct       (ir_q[5:0]),
      .a_eq_b      (a_q == b_q),
      .mem_ready   (mem_ready),
      .ir_we       (ir_we),
      .pc_we       (pc_we),
      .pc_src      (pc_src),
      .ab_we       (ab_we),
      .mdr_we      (mdr_we),
      .aluout_we   (aluout_we),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .rf_we       (rf_we),
      .rf_dst_rd   (rf_dst_rd),
      .rf_from_mdr (rf_from_mdr),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .iord        (iord),
      .retire      (retire),
      .halted      (halted)
   );

   // r0 is hardwired to zero on read; its storage is never written.
   assign rf_rs    = (rs == 5'd0) ? 32'd0 : rf[rs];
   assign rf_rt    = (rt == 5'd0) ? 32'd0 : rf[rt];
   assign rf_waddr = rf_dst_rd ? rd : rt;
   assign rf_wdata = rf_from_mdr ? mdr_q : aluout_q;

   always_ff @(posedge clk) begin
      if (rf_we && (rf_waddr != 5'd0)) begin
         rf[rf_waddr] <= rf_wdata;
      end
   end

   always_comb begin
      alu_a = alu_src_a ? a_q : pc_q;
      case (alu_src_b)
         AluBReg:   alu_b = b_q;
         AluBFour:  alu_b = 32'd4;
         AluBImm:   alu_b = imm_ext;
         AluBImmSh: alu_b = {imm_ext[29:0], 2'b00};
         default:   alu_b = b_q;
      endcase
      case (alu_op)
         AluAdd:  alu_y = alu_a + alu_b;
         AluSub:  alu_y = alu_a - alu_b;
         AluAnd:  alu_y = alu_a & alu_b;
         AluOr:   alu_y = alu_a | alu_b;
         AluSlt:  alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_y = alu_a + alu_b;
      endcase
   end

   always_comb begin
      case (pc_src)
         PcAlu:    pc_next = alu_y;
         PcAluOut: pc_next = aluout_q;
         PcJump:   pc_next = {pc_q[31:28], ir_q[25:0], 2'b00};
         default:  pc_next = alu_y;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         ir_q     <= '0;
         mdr_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         aluout_q <= '0;
      end else begin
         if (pc_we)     pc_q     <= pc_next;
         if (ir_we)     ir_q     <= mem_rdata;
         if (mdr_we)    mdr_q    <= mem_rdata;
         if (ab_we) begin
            a_q <= rf_rs;
            b_q <= rf_rt;
         end
         if (aluout_we) aluout_q <= alu_y;
      end
   end

   assign addr_full = iord ? aluout_q : pc_q;
   assign mem_addr  = addr_full[ADDR_W-1:0];
   assign mem_wdata = b_q;
   assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: table of instructions with hand-computed
// cycle counts, stores and next PCs, plus reset/halt/wait-state sequences.
module tb_multicycle_core;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_req, mem_we, mem_ready, retire, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

   logic [31:0] mem [256];
   logic        load_en;
   logic [7:0]  load_idx;
   logic [31:0] load_data;
   int          stall_total;
   int          stall_seen = 0;
   logic        stall_match;
   int          wr_cnt = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      int          cycles;
      int          stall;
      int          dcyc;
      logic        store;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] next_pc;
   } vec_t;

   vec_t vecs [25];

   multicycle_core #(
      .RESET_PC (32'h0000_0100),
      .ADDR_W   (32),
      .ENABLE_J (1'b1)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .retire    (retire),
      .halted    (halted),
      .pc_dbg    (pc_dbg)
   );

   always #5 clk = ~clk;

   // Word memory; reads at 0x40 can be held off for stall_total cycles.
   assign mem_rdata   = mem[mem_addr[9:2]];
   assign stall_match = !mem_we && (mem_addr == 32'h40);
   assign mem_ready   = mem_req && !(stall_match && (stall_seen < stall_total));

   always @(posedge clk) begin
      if (!rst_n) stall_seen <= 0;
      else if (mem_req && stall_match && !mem_ready) stall_seen <= stall_seen + 1;
      if (load_en) begin
         mem[load_idx] <= load_data;
      end else if (mem_req && mem_ready && mem_we) begin
         mem[mem_addr[9:2]] <= mem_wdata;
         wr_addr <= mem_addr;
         wr_data <= mem_wdata;
         wr_cnt  <= wr_cnt + 1;
      end
   end

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] instr,
                               input int cycles, input int stall, input int dcyc,
                               input logic store, input logic [31:0] waddr,
                               input logic [31:0] wdata, input logic [31:0] next_pc);
      vec_t v;
      v.pc = pc; v.instr = instr; v.cycles = cycles; v.stall = stall; v.dcyc = dcyc;
      v.store = store; v.waddr = waddr; v.wdata = wdata; v.next_pc = next_pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] data);
      load_idx  = addr[9:2];
      load_data = data;
      load_en   = 1'b1;
      step();
      load_en   = 1'b0;
   endtask

   // Entered at the sample point of the instruction's FETCH cycle.
   task automatic run_instr(input vec_t v);
      int          n, dcyc, wr0;
      bit          done;
      logic [31:0] daddr;
      logic        dwe;
      n = 0; dcyc = 0; done = 1'b0; daddr = '0; dwe = 1'b0; wr0 = wr_cnt;
      stall_total = v.stall;
      chk("fetch_req", 32'(mem_req), 32'd1);
      chk("fetch_addr", mem_addr, v.pc);
      while (!done && n < 40) begin
         n++;
         if (n == 2) chk("pc_after_fetch", pc_dbg, v.pc + 32'd4);
         if (n > 1 && mem_req) begin
            if (dcyc == 0) begin
               daddr = mem_addr;
               dwe   = mem_we;
            end else begin
               chk("data_addr_stable", mem_addr, daddr);
               chk("data_we_stable", 32'(mem_we), 32'(dwe));
            end
            dcyc++;
         end
         if (retire) done = 1'b1;
         else step();
      end
      chk("retire_seen", 32'(done), 32'd1);
      chk("cycles", n, v.cycles);
      chk("data_cycles", dcyc, v.dcyc);
      step();
      chk("retire_pulse", 32'(retire), 32'd0);
      chk("store_count", wr_cnt - wr0, 32'(v.store));
      if (v.store) begin
         chk("store_addr", wr_addr, v.waddr);
         chk("store_data", wr_data, v.wdata);
      end
      chk("next_pc", mem_addr, v.next_pc);
   endtask

   initial begin
      rst_n       = 1'b0;
      load_en     = 1'b0;
      load_idx    = '0;
      load_data   = '0;
      stall_total = 0;

      vecs[0]  = mk(32'h100, enc_i(6'b001000, 0, 1, 16'd5), 4, 0, 0, 0, 0, 0, 32'h104);
      vecs[1]  = mk(32'h104, enc_i(6'b001000, 0, 2, 16'd7), 4, 0, 0, 0, 0, 0, 32'h108);
      vecs[2]  = mk(32'h108, enc_r(1, 2, 3, 6'b100000), 4, 0, 0, 0, 0, 0, 32'h10C);
      vecs[3]  = mk(32'h10C, enc_i(6'b101011, 0, 3, 16'h40), 4, 0, 1, 1, 32'h40, 32'd12,
                    32'h110);
      vecs[4]  = mk(32'h110, enc_i(6'b100011, 0, 4, 16'h40), 8, 3, 4, 0, 0, 0, 32'h114);
      vecs[5]  = mk(32'h114, enc_i(6'b101011, 0, 4, 16'h44), 4, 0, 1, 1, 32'h44, 32'd12,
                    32'h118);
      vecs[6]  = mk(32'h118, enc_i(6'b000100, 1, 2, 16'd5), 3, 0, 0, 0, 0, 0, 32'h11C);
      vecs[7]  = mk(32'h11C, enc_i(6'b001000, 0, 6, 16'hFFFF), 4, 0, 0, 0, 0, 0, 32'h120);
      vecs[8]  = mk(32'h120, enc_i(6'b001000, 0, 7, 16'd1), 4, 0, 0, 0, 0, 0, 32'h124);
      vecs[9]  = mk(32'h124, enc_r(6, 7, 5, 6'b101010), 4, 0, 0, 0, 0, 0, 32'h128);
      vecs[10] = mk(32'h128, enc_i(6'b101011, 0, 5, 16'h48), 4, 0, 1, 1, 32'h48, 32'd1,
                    32'h12C);
      vecs[11] = mk(32'h12C, enc_i(6'b100011, 0, 8, 16'h80), 5, 0, 1, 0, 0, 0, 32'h130);
      vecs[12] = mk(32'h130, enc_r(8, 7, 9, 6'b100000), 4, 0, 0, 0, 0, 0, 32'h134);
      vecs[13] = mk(32'h134, enc_i(6'b101011, 0, 9, 16'h4C), 4, 0, 1, 1, 32'h4C,
                    32'h8000_0000, 32'h138);
      vecs[14] = mk(32'h138, enc_r(1, 2, 10, 6'b100010), 4, 0, 0, 0, 0, 0, 32'h13C);
      vecs[15] = mk(32'h13C, enc_i(6'b101011, 0, 10, 16'h50), 4, 0, 1, 1, 32'h50,
                    32'hFFFF_FFFE, 32'h140);
      vecs[16] = mk(32'h140, enc_r(3, 1, 11, 6'b100101), 4, 0, 0, 0, 0, 0, 32'h144);
      vecs[17] = mk(32'h144, enc_i(6'b101011, 0, 11, 16'h54), 4, 0, 1, 1, 32'h54, 32'd13,
                    32'h148);
      vecs[18] = mk(32'h148, enc_r(3, 11, 12, 6'b100100), 4, 0, 0, 0, 0, 0, 32'h14C);
      vecs[19] = mk(32'h14C, enc_i(6'b101011, 0, 12, 16'h58), 4, 0, 1, 1, 32'h58, 32'd12,
                    32'h150);
      vecs[20] = mk(32'h150, enc_r(1, 2, 0, 6'b100000), 4, 0, 0, 0, 0, 0, 32'h154);
      vecs[21] = mk(32'h154, enc_i(6'b101011, 0, 0, 16'h5C), 4, 0, 1, 1, 32'h5C, 32'd0,
                    32'h158);
      vecs[22] = mk(32'h158, {6'b000010, 26'h58}, 3, 0, 0, 0, 0, 0, 32'h160);
      vecs[23] = mk(32'h160, enc_i(6'b000100, 1, 1, 16'hFFFF), 3, 0, 0, 0, 0, 0, 32'h160);
      vecs[24] = vecs[23];

      // Program load while held in reset.
      step();
      for (int i = 0; i < 25; i++) load(vecs[i].pc, vecs[i].instr);
      load(32'h15C, 32'hFC00_0000);
      load(32'h80, 32'h7FFF_FFFF);

      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_pc", pc_dbg, 32'h100);
      rst_n = 1'b1;
      chk("req_before_edge", 32'(mem_req), 32'd0);
      step();

      for (int i = 0; i < 25; i++) run_instr(vecs[i]);

      // Jump to an illegal opcode, then check the halt is terminal.
      rst_n = 1'b0;
      step();
      load(32'h100, {6'b000010, 26'h50});
      load(32'h140, 32'hFC00_0000);
      rst_n = 1'b1;
      step();
      run_instr(mk(32'h100, {6'b000010, 26'h50}, 3, 0, 0, 0, 0, 0, 32'h140));
      step();
      chk("halted_in_decode", 32'(halted), 32'd0);
      step();
      chk("halted_set", 32'(halted), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("halt_no_req", 32'(mem_req), 32'd0);
         chk("halt_no_retire", 32'(retire), 32'd0);
         chk("halt_sticky", 32'(halted), 32'd1);
         step();
      end

      // Reset clears halt; then abort a stalled lw with reset.
      rst_n = 1'b0;
      step();
      chk("halt_cleared", 32'(halted), 32'd0);
      chk("halt_rst_pc", pc_dbg, 32'h100);
      load(32'h100, enc_i(6'b100011, 0, 4, 16'h40));
      stall_total = 100;
      rst_n = 1'b1;
      step();
      chk("abort_fetch_addr", mem_addr, 32'h100);
      repeat (3) step();
      chk("abort_rd_req", 32'(mem_req), 32'd1);
      chk("abort_rd_addr", mem_addr, 32'h40);
      chk("abort_rd_we", 32'(mem_we), 32'd0);
      repeat (2) step();
      chk("abort_rd_hold", mem_addr, 32'h40);
      rst_n = 1'b0;
      step();
      chk("abort_req_low", 32'(mem_req), 32'd0);
      chk("abort_pc", pc_dbg, 32'h100);
      chk("abort_halted", 32'(halted), 32'd0);
      chk("abort_retire", 32'(retire), 32'd0);
      stall_total = 0;
      rst_n = 1'b1;
      step();
      chk("restart_req", 32'(mem_req), 32'd1);
      chk("restart_addr", mem_addr, 32'h100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
